// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder with fixed read latency and a program-load port
// Define IMEM_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter is preloaded with LATENCY-1 so RESP is entered LATENCY edges after acceptance.
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  function automatic logic [AW-1:0] mem_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return word_of(a) < 32'(DEPTH_WORDS);
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && in_range(a);
  endfunction

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] idx_q;
  logic          fault_q;
  logic          fast_path;

`ifdef IMEM_PREFETCH_EN
  logic          pf_valid;
  logic [31:0]   pf_addr;
  logic [31:0]   pf_data;
  logic [31:0]   addr_q;
  logic          hit_q;
  logic          req_hit;
  logic          rsp_done;
  logic [31:0]   next_addr;

  assign req_hit   = pf_valid && (req_addr == pf_addr);
  assign fast_path = !addr_ok(req_addr) || req_hit;
  assign rsp_done  = (state == S_RESP) && rsp_ready && !rsp_fault;
  assign next_addr = addr_q + 32'd4;
`else
  assign fast_path = !addr_ok(req_addr);
`endif

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      fault_q   <= 1'b0;
      rsp_instr <= 32'd0;
      rsp_fault <= 1'b0;
`ifdef IMEM_PREFETCH_EN
      addr_q    <= 32'd0;
      hit_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            idx_q    <= mem_idx(req_addr);
            fault_q  <= !addr_ok(req_addr);
            wait_cnt <= fast_path ? 4'd0 : WAIT_INIT;
            state    <= S_WAIT;
`ifdef IMEM_PREFETCH_EN
            addr_q   <= req_addr;
            hit_q    <= req_hit;
`endif
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_fault <= fault_q;
            // Array read happens on the same edge as any load write, so the old word is returned.
`ifdef IMEM_PREFETCH_EN
            rsp_instr <= fault_q ? 32'd0 : (hit_q ? pf_data : mem[idx_q]);
`else
            rsp_instr <= fault_q ? 32'd0 : mem[idx_q];
`endif
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_instr <= 32'd0;
            rsp_fault <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Program array has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (ld_en && addr_ok(ld_addr)) begin
      mem[mem_idx(ld_addr)] <= ld_data;
    end
  end

`ifdef IMEM_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_valid <= 1'b0;
      pf_addr  <= 32'd0;
      pf_data  <= 32'd0;
    end else if (rsp_done) begin
      pf_addr  <= next_addr;
      pf_data  <= mem[mem_idx(next_addr)];
      pf_valid <= in_range(next_addr) && !(ld_en && (word_of(ld_addr) == word_of(next_addr)));
    end else begin
      if ((state == S_IDLE) && req_valid && !req_hit) begin
        pf_valid <= 1'b0;
      end
      if (ld_en && (word_of(ld_addr) == word_of(pf_addr))) begin
        pf_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder against a transaction-level model
module tb_imem_responder;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  bit          clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [31:0] ld_data = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  imem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending request counts down its latency, then a response is held.
  logic [31:0] mem_m [DEPTH];
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_left = 0;
  bit          m_pfault = 0;
  int          m_pidx = 0;
  logic [31:0] m_instr = 32'd0;
  bit          m_fault = 0;

  function automatic bit m_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && ((off / 4) < DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_left = 0; m_instr = 32'd0; m_fault = 0;
    end else begin
      if (m_resp) begin
        if (rsp_ready) begin
          m_resp = 0; m_instr = 32'd0; m_fault = 0;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          m_resp  = 1;
          m_fault = m_pfault;
          m_instr = m_pfault ? 32'd0 : mem_m[m_pidx];
        end
      end else if (req_valid) begin
        m_busy   = 1;
        m_pfault = !m_ok(req_addr);
        m_left   = m_pfault ? 1 : LAT;
        m_pidx   = m_pfault ? 0 : m_idx(req_addr);
      end
      if (ld_en && m_ok(ld_addr)) mem_m[m_idx(ld_addr)] = ld_data;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_req_ready", 32'(req_ready), 32'(!m_busy && !m_resp));
      chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("cmp_rsp_instr", rsp_instr, m_instr);
      chk("cmp_rsp_fault", 32'(rsp_fault), 32'(m_fault));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
  endtask

  // Returns edges from acceptance to rsp_valid; 20 marks a timeout.
  task automatic fetch(input logic [31:0] a, output int lat);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r == 6) return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    else if (r == 7) return BASE - 32'(4 * $urandom_range(1, 4));
    else if (r == 8) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
    else             return $urandom;
  endfunction

  initial begin
    int lat;
    repeat (3) tick;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(BASE + 32'(4 * i), $urandom);

    load(32'h3000, 32'h2001_0005);
    fetch(32'h3000, lat);
    chk("basic_latency", 32'(lat), 32'd2);
    chk("basic_instr", rsp_instr, 32'h2001_0005);
    chk("basic_fault", 32'(rsp_fault), 32'd0);
    release_rsp;
    chk("basic_idle_after", 32'(req_ready), 32'd1);

    fetch(32'h3002, lat);
    chk("misalign_latency", 32'(lat), 32'd1);
    chk("misalign_fault", 32'(rsp_fault), 32'd1);
    chk("misalign_instr", rsp_instr, 32'd0);
    release_rsp;
    fetch(32'h2FFC, lat);
    chk("below_base_fault", 32'(rsp_fault), 32'd1);
    release_rsp;
    fetch(32'h4000, lat);
    chk("past_end_fault", 32'(rsp_fault), 32'd1);
    chk("past_end_latency", 32'(lat), 32'd1);
    release_rsp;
    load(32'h3FFC, 32'h0BAD_F00D);
    fetch(32'h3FFC, lat);
    chk("last_word_fault", 32'(rsp_fault), 32'd0);
    chk("last_word_instr", rsp_instr, 32'h0BAD_F00D);
    release_rsp;

    fetch(32'h3000, lat);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_instr", rsp_instr, 32'h2001_0005);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    release_rsp;
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(req_ready), 32'd1);
    chk("stall_release_instr", rsp_instr, 32'd0);

    load(32'h3020, 32'h1111_1111);
    req_valid = 1'b1; req_addr = 32'h3020;
    tick;
    req_valid = 1'b0;
    tick;
    ld_en = 1'b1; ld_addr = 32'h3020; ld_data = 32'h2222_2222;
    tick;
    ld_en = 1'b0;
    chk("rbw_valid", 32'(rsp_valid), 32'd1);
    chk("rbw_old_data", rsp_instr, 32'h1111_1111);
    release_rsp;
    fetch(32'h3020, lat);
    chk("rbw_new_data", rsp_instr, 32'h2222_2222);
    release_rsp;

    load(32'h3010, 32'hCAFE_0010);
    req_valid = 1'b1; req_addr = 32'h3010;
    tick;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    fetch(32'h3010, lat);
    chk("rst_after_latency", 32'(lat), 32'd2);
    chk("rst_after_instr", rsp_instr, 32'hCAFE_0010);
    release_rsp;

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_addr  = pick_addr();
      rsp_ready = $urandom_range(0, 2) != 0;
      ld_en     = !rst && ($urandom_range(0, 3) == 0);
      ld_addr   = pick_addr();
      ld_data   = $urandom;
      tick;
    end
    rst = 1'b0; req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_3000, byte address of instruction word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words.
REQ-003 SHALL have parameter LATENCY, default 2, read wait cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_addr  input  32  byte address of the requested instruction (PC value).
REQ-008 SHALL have port req_ready  output  1  responder can accept a request.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-012 SHALL have port rsp_fault  output  1  request was misaligned or out of range.
REQ-013 SHALL have port ld_en  input  1  program-load write strobe.
REQ-014 SHALL have port ld_addr  input  32  program-load byte address, same mapping as req_addr.
REQ-015 SHALL have port ld_data  input  32  program-load word.

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 SHALL accept a request on an edge where req_valid && req_ready, registering req_addr.
REQ-018 SHALL map word index = (addr - BASE_ADDR) >> 2 using 32-bit wrap-around subtraction; address is in range iff the index < DEPTH_WORDS.
REQ-019 SHALL flag a fault if addr[1:0] != 0 or the address is out of range.
REQ-020 SHALL, for a faulting request accepted at edge N, go IDLE->RESP at edge N+1 with rsp_fault = 1 and rsp_instr = 0.
REQ-021 SHALL, for a non-faulting request accepted at edge N, go IDLE->WAIT, count LATENCY edges, enter RESP at edge N+LATENCY, with rsp_instr = the array word and rsp_fault = 0.
REQ-022 SHALL capture the array word on the edge entering RESP; a ld_en write to the same word on that edge SHALL NOT be visible (read-before-write).
REQ-023 SHALL hold rsp_valid, rsp_instr and rsp_fault stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the cycle of a response handshake (no back-to-back; req_ready rises the cycle after).
REQ-025 SHALL perform ld_en writes in any state when ld_addr is aligned and in range; other ld_en writes SHALL be silently dropped.
REQ-026 SHALL keep rsp_instr and rsp_fault at 0 whenever rsp_valid = 0.

Reset
REQ-027 SHALL, on rst, force state IDLE, req_ready = 1, rsp_valid = 0, rsp_instr = 0, rsp_fault = 0, wait counter = 0, and clear all prefetch state.
REQ-028 SHALL abandon any in-flight request on rst mid-operation with no response emitted.
REQ-029 SHALL NOT clear array contents on rst.

Configuration
REQ-030 SHALL, when macro IMEM_PREFETCH_EN is defined, include a one-entry sequential prefetch buffer (pf_valid, pf_addr, pf_data).
REQ-031 SHALL, with IMEM_PREFETCH_EN, on a non-faulting response handshake for address A, load pf_addr = A+4 and pf_data = word(A+4), with pf_valid = 1 iff A+4 is in range.
REQ-032 SHALL, with IMEM_PREFETCH_EN, treat an accepted request with pf_valid && req_addr == pf_addr as a hit: IDLE->RESP at edge N+1 with rsp_instr = pf_data.
REQ-033 SHALL, with IMEM_PREFETCH_EN, clear pf_valid on any accepted request that misses, and on any ld_en write whose word index equals pf_addr's index.
REQ-034 SHALL, without IMEM_PREFETCH_EN, contain no prefetch state; every non-faulting request takes LATENCY cycles per REQ-021.

Verification
REQ-035 SHALL cover: load 0x3000<-0x2001_0005, request 0x3000 at edge N, rsp_ready=1 -> rsp_valid at edge N+2, rsp_instr=0x2001_0005, rsp_fault=0.
REQ-036 SHALL cover: request 0x3002 -> rsp_valid at edge N+1, rsp_fault=1, rsp_instr=0; request 0x2FFC and 0x3000+4*1024 -> rsp_fault=1.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_instr stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-038 SHALL cover: rst asserted in WAIT -> rsp_valid never asserts, req_ready=1 immediately; next request served normally.
REQ-039 SHALL cover (IMEM_PREFETCH_EN): requests 0x3000 then 0x3004 -> second response at edge N+1; ld_en to 0x3004 between them -> second response at edge N+2 with new data.
